// File: rtl/cs_pkg.sv
// Shared types and sizing for the compressive-sensing frame sequencer.
// Buffer lengths drive every address width so a resize touches one line.
package cs_pkg;

  localparam int M_LEN   = 64;
  localparam int PHI_LEN = 16384;
  localparam int N_LEN   = 256;

  localparam int X_AW   = $clog2(M_LEN);
  localparam int PHI_AW = $clog2(PHI_LEN);
  localparam int REC_AW = $clog2(N_LEN);

  typedef enum logic [2:0] {
    LOAD_X,
    LOAD_PHI,
    START,
    RUN,
    FETCH,
    SEND
  } state_e;

  // Which load buffer the byte router is currently filling.
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_X,
    PH_PHI
  } phase_e;

endpackage

// File: rtl/cs_frame_sequencer_if.sv
// Handshake bundle between the sequencer, the OMP core (ap_ctrl_hs) and the SPI sender.
interface cs_frame_sequencer_if;

  logic       omp_start;
  logic       omp_ready;
  logic       omp_done;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ack;

  modport master (
    output omp_start, tx_valid, tx_data,
    input  omp_ready, omp_done, tx_ack
  );

  modport slave (
    input  omp_start, tx_valid, tx_data,
    output omp_ready, omp_done, tx_ack
  );

endinterface

// File: rtl/cs_byte_router.sv
// Load-phase byte router: one shared counter demuxes received bytes into the
// measurement or phi buffer with a registered strobe/address/data one cycle later.
module cs_byte_router
  import cs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  phase_e            phase,
  input  logic              clear,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              x_we,
  output logic [X_AW-1:0]   x_addr,
  output logic              phi_we,
  output logic [PHI_AW-1:0] phi_addr,
  output logic [7:0]        wr_data,
  output logic              accept,
  output logic              last,
  output logic              cnt_zero
);

  logic [PHI_AW-1:0] cnt_q, cnt_d;
  logic [PHI_AW-1:0] cnt_max;
  logic              x_we_q, x_we_d;
  logic [X_AW-1:0]   x_addr_q, x_addr_d;
  logic              phi_we_q, phi_we_d;
  logic [PHI_AW-1:0] phi_addr_q, phi_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  // NOTE: every combinational output is given a default first so no branch can infer a latch.
  always_comb begin
    cnt_max    = (phase == PH_X) ? PHI_AW'(M_LEN - 1) : PHI_AW'(PHI_LEN - 1);
    accept     = rx_valid && (phase != PH_IDLE) && !clear;
    last       = accept && (cnt_q == cnt_max);
    cnt_d      = cnt_q;
    x_we_d     = 1'b0;
    x_addr_d   = x_addr_q;
    phi_we_d   = 1'b0;
    phi_addr_d = phi_addr_q;
    wr_data_d  = wr_data_q;

    // An abort drops the byte arriving alongside it.
    if (clear) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d     = last ? '0 : cnt_q + PHI_AW'(1);
      wr_data_d = rx_data;
      if (phase == PH_X) begin
        x_we_d   = 1'b1;
        x_addr_d = cnt_q[X_AW-1:0];
      end else begin
        phi_we_d   = 1'b1;
        phi_addr_d = cnt_q;
      end
    end
  end

  // NOTE: flops use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      x_we_q     <= 1'b0;
      x_addr_q   <= '0;
      phi_we_q   <= 1'b0;
      phi_addr_q <= '0;
      wr_data_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      x_we_q     <= x_we_d;
      x_addr_q   <= x_addr_d;
      phi_we_q   <= phi_we_d;
      phi_addr_q <= phi_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign x_we     = x_we_q;
  assign x_addr   = x_addr_q;
  assign phi_we   = phi_we_q;
  assign phi_addr = phi_addr_q;
  assign wr_data  = wr_data_q;
  assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/cs_frame_sequencer.sv
// Frame controller: load measurement and phi buffers, run the OMP core, then
// stream the reconstruction buffer to the SPI sender one byte per acknowledge.
module cs_frame_sequencer
  import cs_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ssel,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 x_we,
  output logic [X_AW-1:0]      x_addr,
  output logic                 phi_we,
  output logic [PHI_AW-1:0]    phi_addr,
  output logic [7:0]           wr_data,
  output logic                 rec_re,
  output logic [REC_AW-1:0]    rec_addr,
  input  logic [7:0]           rec_rdata,
  output logic                 busy,
  output logic                 frame_err,
  cs_frame_sequencer_if.master bus
);

  state_e            state_q, state_d;
  logic [REC_AW-1:0] idx_q, idx_d;
  logic              fetch_wait_q, fetch_wait_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              omp_start_q, omp_start_d;
  logic              frame_err_q, frame_err_d;
  logic              ssel_q, ssel_d;

  phase_e phase;
  logic   abort;
  logic   accept;
  logic   last;
  logic   cnt_zero;

  assign phase = (state_q == LOAD_X)   ? PH_X   :
                 (state_q == LOAD_PHI) ? PH_PHI : PH_IDLE;

  // A deselect mid-frame aborts; an idle LOAD_X has nothing to abandon.
  assign abort = ssel && !ssel_q &&
                 (((state_q == LOAD_X) && !cnt_zero) || (state_q == LOAD_PHI));

  cs_byte_router u_router (
    .clk      (clk),
    .rst      (rst),
    .phase    (phase),
    .clear    (abort),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .x_we     (x_we),
    .x_addr   (x_addr),
    .phi_we   (phi_we),
    .phi_addr (phi_addr),
    .wr_data  (wr_data),
    .accept   (accept),
    .last     (last),
    .cnt_zero (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    fetch_wait_d = 1'b0;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    frame_err_d  = frame_err_q;
    ssel_d       = ssel;

    case (state_q)
      LOAD_X: begin
        if (abort) begin
          frame_err_d = 1'b1;
        end else if (accept) begin
          if (cnt_zero) frame_err_d = 1'b0;
          if (last)     state_d     = LOAD_PHI;
        end
      end
      LOAD_PHI: begin
        if (abort) begin
          state_d     = LOAD_X;
          frame_err_d = 1'b1;
        end else if (last) begin
          state_d = START;
        end
      end
      START: begin
        if (bus.omp_ready) state_d = bus.omp_done ? FETCH : RUN;
      end
      RUN: begin
        if (bus.omp_done) state_d = FETCH;
      end
      // Two cycles: issue the read, then capture the RAM's registered output.
      FETCH: begin
        if (fetch_wait_q) begin
          tx_data_d  = rec_rdata;
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end else begin
          fetch_wait_d = 1'b1;
        end
      end
      SEND: begin
        if (bus.tx_ack) begin
          tx_valid_d = 1'b0;
          if (idx_q == REC_AW'(N_LEN - 1)) begin
            idx_d   = '0;
            state_d = LOAD_X;
          end else begin
            idx_d   = idx_q + REC_AW'(1);
            state_d = FETCH;
          end
        end
      end
      default: state_d = LOAD_X;
    endcase

    omp_start_d = (state_d == START);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD_X;
      idx_q        <= '0;
      fetch_wait_q <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      omp_start_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      // Select idles high, so seeding high keeps reset release from looking like a rise.
      ssel_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      fetch_wait_q <= fetch_wait_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      omp_start_q  <= omp_start_d;
      frame_err_q  <= frame_err_d;
      ssel_q       <= ssel_d;
    end
  end

  assign rec_re        = (state_q == FETCH) && !fetch_wait_q;
  assign rec_addr      = idx_q;
  assign busy          = !((state_q == LOAD_X) && cnt_zero);
  assign frame_err     = frame_err_q;
  assign bus.omp_start = omp_start_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;

endmodule

// File: tb/tb_cs_frame_sequencer.sv
// Scoreboard bench for cs_frame_sequencer: directed frames push expected buffer
// writes and transmit bytes; negedge monitors pop and compare as the DUT presents them.
module tb_cs_frame_sequencer;
  import cs_pkg::*;

  typedef struct packed {
    logic        is_phi;
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              ssel;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              x_we;
  logic [X_AW-1:0]   x_addr;
  logic              phi_we;
  logic [PHI_AW-1:0] phi_addr;
  logic [7:0]        wr_data;
  logic              rec_re;
  logic [REC_AW-1:0] rec_addr;
  logic [7:0]        rec_rdata;
  logic              busy;
  logic              frame_err;

  cs_frame_sequencer_if bus ();

  cs_frame_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .ssel      (ssel),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .x_we      (x_we),
    .x_addr    (x_addr),
    .phi_we    (phi_we),
    .phi_addr  (phi_addr),
    .wr_data   (wr_data),
    .rec_re    (rec_re),
    .rec_addr  (rec_addr),
    .rec_rdata (rec_rdata),
    .busy      (busy),
    .frame_err (frame_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int   checks;
  int   errors;
  wr_t  wr_q[$];
  logic [7:0] tx_q[$];
  int   tx_seen;
  int   start_windows;
  int   ack_delay;
  int   stray_ack_req;
  int   stray_ack_done;
  int   ack_wait;
  logic omp_coincident;
  logic tx_valid_prev;
  logic omp_start_prev;
  logic [7:0] tx_hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reconstruction RAM preloaded with i ^ 0xA5, one-cycle read latency.
  always @(posedge clk) begin
    if (rec_re) rec_rdata <= rec_addr ^ 8'hA5;
  end

  // Write and transmit monitors.
  initial begin
    tx_seen        = 0;
    start_windows  = 0;
    tx_valid_prev  = 1'b0;
    omp_start_prev = 1'b0;
    tx_hold        = 8'h00;
    forever begin
      @(negedge clk);
      if (x_we && phi_we) begin
        check("dual_write_strobe", 32'(1), 32'(0));
      end else if (x_we || phi_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 32'(1), 32'(0));
        end else begin
          wr_t e;
          wr_t a;
          e = wr_q.pop_front();
          a.is_phi = phi_we;
          a.addr   = phi_we ? 14'(phi_addr) : 14'(x_addr);
          a.data   = wr_data;
          check("buffer_write", 32'(a), 32'(e));
        end
      end
      if (bus.tx_valid && !tx_valid_prev) begin
        if (tx_q.size() == 0) begin
          check("unexpected_tx", 32'(1), 32'(0));
        end else begin
          check("tx_byte", 32'(bus.tx_data), 32'(tx_q.pop_front()));
        end
        tx_seen++;
        tx_hold = bus.tx_data;
      end else if (bus.tx_valid) begin
        check("tx_hold_stable", 32'(bus.tx_data), 32'(tx_hold));
      end
      if (bus.omp_start && !omp_start_prev) start_windows++;
      tx_valid_prev  = bus.tx_valid;
      omp_start_prev = bus.omp_start;
    end
  end

  // SPI sender model: stray acks on request, otherwise ack each byte after ack_delay cycles.
  initial begin
    bus.tx_ack     = 1'b0;
    stray_ack_done = 0;
    ack_wait       = 0;
    forever begin
      @(negedge clk);
      bus.tx_ack = 1'b0;
      if (stray_ack_done < stray_ack_req) begin
        bus.tx_ack = 1'b1;
        stray_ack_done++;
      end else if (bus.tx_valid) begin
        if (ack_wait >= ack_delay) begin
          bus.tx_ack = 1'b1;
          ack_wait   = 0;
        end else begin
          ack_wait++;
        end
      end else begin
        ack_wait = 0;
      end
    end
  end

  // OMP core model: ready 3 cycles after start, done 50 cycles after (or both at 3).
  initial begin
    bus.omp_ready = 1'b0;
    bus.omp_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.omp_start) begin
        repeat (2) @(negedge clk);
        check("omp_start_held", 32'(bus.omp_start), 32'(1));
        bus.omp_ready = 1'b1;
        bus.omp_done  = omp_coincident;
        @(negedge clk);
        bus.omp_ready = 1'b0;
        bus.omp_done  = 1'b0;
        check("omp_start_drop", 32'(bus.omp_start), 32'(0));
        if (!omp_coincident) begin
          repeat (46) @(negedge clk);
          bus.omp_done = 1'b1;
          @(negedge clk);
          bus.omp_done = 1'b0;
        end
      end
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    checks++;
    errors++;
    $display("FAIL watchdog: run exceeded its cycle budget at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic send_byte(input logic [7:0] d, input logic exp_we, input logic is_phi, input int addr);
    wr_t e;
    if (exp_we) begin
      e.is_phi = is_phi;
      e.addr   = 14'(addr);
      e.data   = d;
      wr_q.push_back(e);
    end
    rx_valid = 1'b1;
    rx_data  = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic load_frame(input int first);
    for (int i = first; i < M_LEN; i++) send_byte(8'(i), 1'b1, 1'b0, i);
    for (int i = 0; i < PHI_LEN; i++) send_byte(8'(i & 8'hFF), 1'b1, 1'b1, i);
  endtask

  task automatic push_tx_frame();
    for (int i = 0; i < N_LEN; i++) tx_q.push_back(8'(i) ^ 8'hA5);
  endtask

  task automatic wait_frame_done(input int budget, input string tag);
    int n;
    n = 0;
    while (!(tx_q.size() == 0 && dut.state_q == LOAD_X && !bus.tx_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_completes"}, 32'(n < budget), 32'(1));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_x_we"},      32'(x_we),          32'(0));
    check({tag, "_x_addr"},    32'(x_addr),        32'(0));
    check({tag, "_phi_we"},    32'(phi_we),        32'(0));
    check({tag, "_phi_addr"},  32'(phi_addr),      32'(0));
    check({tag, "_wr_data"},   32'(wr_data),       32'(0));
    check({tag, "_omp_start"}, 32'(bus.omp_start), 32'(0));
    check({tag, "_rec_re"},    32'(rec_re),        32'(0));
    check({tag, "_rec_addr"},  32'(rec_addr),      32'(0));
    check({tag, "_tx_valid"},  32'(bus.tx_valid),  32'(0));
    check({tag, "_tx_data"},   32'(bus.tx_data),   32'(0));
    check({tag, "_busy"},      32'(busy),          32'(0));
    check({tag, "_frame_err"}, 32'(frame_err),     32'(0));
    check({tag, "_state"},     32'(dut.state_q),   32'(LOAD_X));
  endtask

  initial begin
    int n;
    int base;
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    ssel           = 1'b1;
    rx_valid       = 1'b0;
    rx_data        = 8'h00;
    ack_delay      = 0;
    stray_ack_req  = 0;
    omp_coincident = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // Stray acknowledges while idle must not move anything.
    stray_ack_req = 3;
    repeat (5) begin
      @(negedge clk);
      check("stray_ack_no_tx", 32'(bus.tx_valid), 32'(0));
    end
    check("stray_ack_state", 32'(dut.state_q), 32'(LOAD_X));
    check("stray_ack_idx",   32'(dut.idx_q),   32'(0));
    check("stray_ack_busy",  32'(busy),        32'(0));

    // Frame 1: full frame, stray rx bytes during RUN.
    ssel = 1'b0;
    push_tx_frame();
    load_frame(0);
    n = 0;
    while (dut.state_q != RUN && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reach_run", 32'(n < 50), 32'(1));
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hC0 + 8'(i), 1'b0, 1'b0, 0);
      check("run_rx_no_write", 32'({x_we, phi_we}), 32'(0));
    end
    check("run_rx_cnt", 32'(dut.u_router.cnt_q), 32'(0));
    wait_frame_done(3000, "frame1");
    check("frame1_busy_low",   32'(busy),          32'(0));
    check("frame1_one_window", 32'(start_windows), 32'(1));

    // Abort in LOAD_PHI after 64 + 100 bytes; the byte on the ssel rise is dropped.
    for (int i = 0; i < M_LEN; i++) send_byte(8'(i), 1'b1, 1'b0, i);
    for (int i = 0; i < 100; i++) send_byte(8'(i), 1'b1, 1'b1, i);
    check("pre_abort_busy", 32'(busy),      32'(1));
    check("pre_abort_err",  32'(frame_err), 32'(0));
    ssel     = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    @(negedge clk);
    rx_valid = 1'b0;
    ssel     = 1'b0;
    check("abort_err_set",  32'(frame_err),             32'(1));
    check("abort_state",    32'(dut.state_q),           32'(LOAD_X));
    check("abort_no_write", 32'({x_we, phi_we}),        32'(0));
    check("abort_cnt",      32'(dut.u_router.cnt_q),    32'(0));
    check("abort_busy",     32'(busy),                  32'(0));
    @(negedge clk);
    check("abort_err_sticky", 32'(frame_err), 32'(1));

    // Frame 2: coincident ready/done and 40-cycle backpressure on every byte.
    omp_coincident = 1'b1;
    ack_delay      = 40;
    push_tx_frame();
    send_byte(8'h00, 1'b1, 1'b0, 0);
    check("new_frame_err_clear", 32'(frame_err), 32'(0));
    check("new_frame_x_addr0",   32'({x_we, 6'(x_addr)}), 32'({1'b1, 6'd0}));
    load_frame(1);
    wait_frame_done(15000, "frame2");
    check("frame2_windows", 32'(start_windows), 32'(2));

    // Frame 3: reset while byte 100 is being sent, then reload from address 0.
    omp_coincident = 1'b0;
    ack_delay      = 0;
    base           = tx_seen;
    push_tx_frame();
    load_frame(0);
    n = 0;
    while (tx_seen < base + 101 && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("reach_byte100", 32'(n < 5000), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst_mid_send");
    tx_q.delete();
    rst = 1'b0;
    send_byte(8'h11, 1'b1, 1'b0, 0);
    send_byte(8'h22, 1'b1, 1'b0, 1);
    send_byte(8'h33, 1'b1, 1'b0, 2);
    @(negedge clk);
    check("reload_state",     32'(dut.state_q),        32'(LOAD_X));
    check("reload_cnt",       32'(dut.u_router.cnt_q), 32'(3));
    check("reload_busy",      32'(busy),               32'(1));
    check("reload_frame_err", 32'(frame_err),          32'(0));
    check("wr_queue_drained", 32'(wr_q.size()),        32'(0));
    check("total_windows",    32'(start_windows),      32'(3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cs_frame_sequencer.md
Name: cs_frame_sequencer

Overview:
- Top-level controller for the compressive-sensing receive/reconstruct/transmit flow.
- Consumes the SPI receiver byte stream and routes bytes into the measurement buffer (64 bytes), then the phi-matrix buffer (16384 bytes).
- Launches the OMP core with an ap_ctrl_hs handshake, then streams the 256-byte reconstruction buffer to the SPI sender one byte per acknowledge.
- Sits between signalReceive, the three on-chip RAMs, OMP_0 and sending.

Parameters:
- M_LEN, 64, measurement bytes per frame
- PHI_LEN, 16384, phi-matrix bytes per frame
- N_LEN, 256, reconstructed bytes returned per frame
- X_AW, 6, measurement buffer address width
- PHI_AW, 14, phi buffer address width
- REC_AW, 8, reconstruction buffer address width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ssel  in  1  SPI slave select, active low
- rx_valid  in  1  one-cycle pulse: rx_data holds a new byte
- rx_data  in  8  received byte
- x_we  out  1  measurement buffer write strobe
- x_addr  out  X_AW  measurement buffer write address
- phi_we  out  1  phi buffer write strobe
- phi_addr  out  PHI_AW  phi buffer write address
- wr_data  out  8  write data shared by both buffers (registered rx_data)
- omp_start  out  1  ap_start to OMP core
- omp_ready  in  1  ap_ready from OMP core
- omp_done  in  1  ap_done from OMP core
- rec_re  out  1  reconstruction buffer read enable
- rec_addr  out  REC_AW  reconstruction buffer read address
- rec_rdata  in  8  read data, valid 1 cycle after rec_re
- tx_valid  out  1  tx_data is valid for the sender
- tx_data  out  8  byte to transmit
- tx_ack  in  1  one-cycle pulse from sender: byte consumed
- busy  out  1  high in every state except LOAD_X with x count 0
- frame_err  out  1  sticky abort flag; cleared by rst or by the first byte of a new frame

Behaviour:
- Reset: state LOAD_X, all counters 0. Every output is 0, including wr_data, tx_data, rec_addr, x_addr and phi_addr.
- LOAD_X:
  - On rx_valid, next cycle: x_we=1, x_addr=count, wr_data=rx_data, count+1.
  - The write that fills M_LEN-1 moves the state to LOAD_PHI and clears the counter.
- LOAD_PHI:
  - Same behaviour on phi_we/phi_addr.
  - The write that fills PHI_LEN-1 moves the state to START.
- Write latency is exactly 1 cycle from rx_valid. Counters never wrap within a frame.
- Abort on ssel rising:
  - Applies in LOAD_X (count>0) or LOAD_PHI.
  - Sets frame_err, returns to LOAD_X with counters cleared.
  - Any partially written data is ignored.
  - If rx_valid arrives in the same cycle as the ssel rise, the byte is dropped.
- rx_valid in START/RUN/FETCH/SEND is ignored; no buffer write occurs.
- START:
  - omp_start=1 held until omp_ready sampled high. omp_start drops the following cycle; state moves to RUN.
  - If omp_done is high together with omp_ready, go directly to FETCH.
- RUN: wait for omp_done, then FETCH with rec index 0.
- FETCH:
  - rec_re=1, rec_addr=index for one cycle.
  - Next cycle: tx_data<=rec_rdata, tx_valid=1, state SEND.
- SEND:
  - Hold tx_valid/tx_data until tx_ack.
  - On tx_ack: tx_valid=0. If index==N_LEN-1, go to LOAD_X with counters cleared. Otherwise index+1 and go to FETCH.
  - The first byte sent is always address 0.
- tx_ack outside SEND is ignored.
- Throughput: at least 2 cycles between tx_ack and the next tx_valid.
- rst mid-operation:
  - Immediate return to reset state; omp_start drops the same edge.
  - The OMP core is reset by its own ap_rst, not by this block.

Decomposition:
- Shared package cs_pkg:
  - state enum {LOAD_X, LOAD_PHI, START, RUN, FETCH, SEND}
  - M_LEN, PHI_LEN and N_LEN constants
  - address-width localparams, derived with $clog2
- Sub-module cs_byte_router: the load-phase counter/demux (rx byte -> x/phi strobe, address, data, last flag). Reused if the phi source later moves to flash.
- The FSM and transmit logic stay in cs_frame_sequencer.

Test Plan:
- Full frame:
  - Stimulus: 64 bytes 0x00..0x3F, then 16384 bytes (addr&0xFF); OMP model asserts ready 3 cycles and done 50 cycles after start; rec RAM preloaded with i^0xA5.
  - Response: x writes at addr 0..63; phi writes at addr 0..16383; exactly one omp_start window; 256 tx bytes in order, first 0xA5, last 0x5A; busy drops afterwards.
- Abort in LOAD_PHI:
  - Stimulus: ssel rises after 64+100 bytes.
  - Response: frame_err=1; state LOAD_X; next byte written at x_addr 0; frame_err clears on that byte.
- Ready/done coincident:
  - Stimulus: omp_ready and omp_done in the same cycle.
  - Response: omp_start deasserts next cycle; FETCH of addr 0 follows with no hang.
- Backpressure:
  - Stimulus: tx_ack delayed 40 cycles per byte.
  - Response: tx_data stable while tx_valid; no skipped or repeated addresses.
- Stray inputs:
  - Stimulus: rx_valid pulses during RUN; tx_ack pulses during LOAD_X.
  - Response: no x_we or phi_we; no counter change.
- Reset mid-SEND:
  - Stimulus: rst at byte 100.
  - Response: all outputs 0 next cycle; a new frame loads from x_addr 0.
